// File: rtl/monocycle_loader.sv
// Boot/run controller for the monocycle core: receives a little-endian program image over a
// valid/ready byte link, writes it into instruction memory, then runs the core for a fixed length.
module monocycle_loader #(
  parameter int unsigned IMEM_AW    = 10,
  parameter int unsigned RST_HOLD   = 1,
  parameter int unsigned RUN_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ld_valid,
  input  logic [7:0]         ld_data,
  output logic               ld_ready,
  input  logic               restart,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               core_reset,
  output logic [31:0]        initial_address,
  output logic               core_tr,
  output logic               done
);

  typedef enum logic [2:0] {
    HDR,
    LOAD,
    HOLD,
    RUN,
    DONE
  } state_t;

  localparam logic [15:0] HOLD_LAST = 16'(RST_HOLD - 1);
  localparam logic [15:0] RUN_LAST  = 16'(RUN_CYCLES - 1);

  state_t             state;
  state_t             state_n;
  logic [2:0]         byte_cnt;
  logic [29:0]        addr_hi;
  logic [7:0]         cnt_lo;
  logic [23:0]        word_lo;
  logic [IMEM_AW-1:0] ptr;
  logic [15:0]        words_left;
  logic [15:0]        cyc_cnt;
  logic               accept;
  logic               hdr_last;
  logic               word_last;
  logic [15:0]        hdr_count;

  assign accept    = ld_valid && ld_ready;
  assign hdr_last  = accept && (state == HDR) && (byte_cnt == 3'd5);
  assign word_last = accept && (state == LOAD) && (byte_cnt == 3'd3);
  assign hdr_count = {ld_data, cnt_lo};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= HDR;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    ld_ready   = 1'b0;
    core_reset = 1'b1;
    core_tr    = 1'b0;
    done       = 1'b0;
    unique case (state)
      HDR: begin
        ld_ready = reset;
        if (hdr_last) begin
          state_n = (hdr_count != 16'd0) ? LOAD : HOLD;
        end
      end
      LOAD: begin
        ld_ready = reset;
        if (word_last && (words_left == 16'd1)) begin
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (cyc_cnt == HOLD_LAST) begin
          state_n = RUN;
        end
      end
      RUN: begin
        core_reset = 1'b0;
        if (cyc_cnt == RUN_LAST) begin
          state_n = DONE;
        end
      end
      DONE: begin
        core_reset = 1'b0;
        core_tr    = 1'b1;
        done       = 1'b1;
        if (restart) begin
          state_n = HDR;
        end
      end
      default: state_n = HDR;
    endcase
  end

  // Bytes shift in from the top, so after four header bytes addr_hi holds addr[31:2] and
  // after three data bytes word_lo holds the low 24 bits of the word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_we         <= 1'b0;
      imem_addr       <= '0;
      imem_wdata      <= '0;
      initial_address <= '0;
      byte_cnt        <= '0;
      addr_hi         <= '0;
      cnt_lo          <= '0;
      word_lo         <= '0;
      ptr             <= '0;
      words_left      <= '0;
      cyc_cnt         <= '0;
    end else begin
      imem_we <= 1'b0;

      if (accept && (state == HDR)) begin
        if (byte_cnt < 3'd4) begin
          addr_hi  <= {ld_data, addr_hi[29:8]};
          byte_cnt <= byte_cnt + 3'd1;
        end else if (byte_cnt == 3'd4) begin
          cnt_lo   <= ld_data;
          byte_cnt <= byte_cnt + 3'd1;
        end else begin
          initial_address <= {addr_hi, 2'b00};
          ptr             <= addr_hi[IMEM_AW-1:0];
          words_left      <= hdr_count;
          byte_cnt        <= '0;
        end
      end

      if (accept && (state == LOAD)) begin
        if (word_last) begin
          imem_we    <= 1'b1;
          imem_addr  <= ptr;
          imem_wdata <= {ld_data, word_lo};
          ptr        <= ptr + 1'b1;
          words_left <= words_left - 16'd1;
          byte_cnt   <= '0;
        end else begin
          word_lo  <= {ld_data, word_lo[23:8]};
          byte_cnt <= byte_cnt + 3'd1;
        end
      end

      if (state_n != state) begin
        cyc_cnt <= '0;
      end else if ((state == HOLD) || (state == RUN)) begin
        cyc_cnt <= cyc_cnt + 16'd1;
      end
    end
  end

endmodule
